instruction_sequencer: RTL and testbench

Instruction issuer that drives the `core` instruction input. It is the initiator side of the instruction port: on `start` it fetches `prog_len` 15-bit instructions from a synchronous instruction ROM and presents each one to the core for `HOLD_CYCLES` clocks. A NOP is driven between instructions and whenever the sequencer is idle. It replaces bench-driven instruction stimulus in integration and on the FPGA top level.

---
 rtl/instruction_sequencer_if.sv | 11 +
 rtl/instruction_sequencer.sv | 81 ++++++++
 tb/tb_instruction_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: synchronous instruction ROM read port (master = sequencer, slave = ROM)
interface instruction_sequencer_if #(
  parameter int PC_WIDTH = 8,
  parameter int INSTRUCTION_WIDTH = 15
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic imem_rd;
  logic [INSTRUCTION_WIDTH-1:0] imem_data;
  modport master (output imem_addr, imem_rd, input imem_data);
  modport slave (input imem_addr, imem_rd, output imem_data);
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches prog_len ROM words and issues each to the core for HOLD_CYCLES clocks, NOP otherwise
module instruction_sequencer #(
  parameter int INSTRUCTION_WIDTH = 15,
  parameter int PC_WIDTH = 8,
  parameter int HOLD_CYCLES = 2,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD = 15'b1_0000_1011_00_00_00
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  input logic halt,
  input logic [PC_WIDTH-1:0] prog_len,
  instruction_sequencer_if.master imem,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0] pc,
  output logic busy,
  output logic done
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, ISSUE} state_t;
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, len_q, len_d;
  logic [7:0] hold_q, hold_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic done_q, done_d;
  assign imem.imem_addr = pc_q;
  assign imem.imem_rd = state_q == FETCH;
  assign instruction = instr_q;
  assign pc = pc_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    len_d = len_q;
    hold_d = hold_q;
    instr_d = instr_q;
    done_d = 1'b0;
    if (halt) begin
      state_d = IDLE;
      instr_d = NOP_WORD;
    end else if (state_q == IDLE) begin
      instr_d = NOP_WORD;
      done_d = start && prog_len == '0;
      if (start && prog_len != '0) begin
        len_d = prog_len;
        pc_d = '0;
        state_d = FETCH;
      end
    end else if (state_q == FETCH) begin
      state_d = LOAD;
    end else if (state_q == LOAD) begin
      instr_d = imem.imem_data;
      hold_d = 8'(HOLD_CYCLES - 1);
      state_d = ISSUE;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 8'd1;
    end else begin
      instr_d = NOP_WORD;
      done_d = pc_q == len_q - PC_WIDTH'(1);
      state_d = done_d ? IDLE : FETCH;
      pc_d = done_d ? pc_q : pc_q + PC_WIDTH'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      len_q <= '0;
      hold_q <= '0;
      instr_q <= NOP_WORD;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      len_q <= len_d;
      hold_q <= hold_d;
      instr_q <= instr_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: scoreboard bench with a program-level reference model and an independent output monitor
module tb_instruction_sequencer;
  localparam int HOLD = 2;
  localparam int P = HOLD + 2;
  localparam logic [14:0] NOP = 15'b100001011000000;
  typedef struct { logic [14:0] word; int hold; } word_t;
  typedef struct { logic [7:0] pc; logic done; int blen; } end_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic [7:0] prog_len = '0;
  logic [14:0] instruction;
  logic [7:0] pc;
  logic busy, done;
  logic [14:0] rom [256];
  word_t wq[$];
  logic [7:0] aq[$];
  end_t eq[$];
  logic [7:0] model_pc = '0;
  int checks = 0;
  int errors = 0;
  instruction_sequencer_if #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(15)) imem_bus ();
  instruction_sequencer #(.INSTRUCTION_WIDTH(15), .PC_WIDTH(8), .HOLD_CYCLES(HOLD), .NOP_WORD(NOP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .halt(halt),
    .prog_len(prog_len),
    .imem(imem_bus),
    .instruction(instruction),
    .pc(pc),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_bus.imem_rd) imem_bus.imem_data <= rom[imem_bus.imem_addr];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask
  function automatic logic [14:0] rand_word();
    logic [14:0] w;
    do w = 15'($urandom); while (w == NOP);
    return w;
  endfunction
  // Expected behaviour of one run: every instruction occupies a P-clock slot (FETCH, LOAD, HOLD issue clocks);
  // a halt sampled at edge h cuts the run inside slot (h-1)/P.
  task automatic expect_run(input int len, input int h);
    int t, i, ph;
    if (len == 0) begin
      eq.push_back('{model_pc, 1'b1, 0});
    end else if (h == 0 || h > len * P) begin
      for (int k = 0; k < len; k++) begin
        wq.push_back('{rom[k], HOLD});
        aq.push_back(8'(k));
      end
      model_pc = 8'(len - 1);
      eq.push_back('{model_pc, 1'b1, len * P});
    end else begin
      t = h - 1;
      i = t / P;
      ph = t % P;
      for (int k = 0; k < i; k++) begin
        wq.push_back('{rom[k], HOLD});
        aq.push_back(8'(k));
      end
      aq.push_back(8'(i));
      if (ph >= 2) wq.push_back('{rom[i], ph - 1});
      model_pc = 8'(i);
      eq.push_back('{model_pc, 1'b0, h});
    end
  endtask
  task automatic run(input int len, input int h, input int sp);
    int c;
    expect_run(len, h);
    @(posedge clk) #1;
    start = 1'b1;
    prog_len = 8'(len);
    @(posedge clk) #1;
    start = 1'b0;
    prog_len = 8'($urandom);
    for (c = 0; c < 3000 && busy; c++) begin
      halt = h != 0 && c == h - 1;
      start = sp != 0 && c == sp;
      @(posedge clk) #1;
    end
    halt = 1'b0;
    start = 1'b0;
    if (busy) fail("run_timeout");
    repeat (3) @(posedge clk);
  endtask
  initial begin : monitor
    logic [14:0] prev_ins;
    logic prev_busy;
    int blen, run_len;
    word_t cur;
    bit have_cur;
    end_t e;
    prev_ins = NOP;
    prev_busy = 1'b0;
    blen = 0;
    run_len = 0;
    have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ins = NOP;
        prev_busy = 1'b0;
        blen = 0;
        run_len = 0;
        have_cur = 1'b0;
      end else begin
        if (imem_bus.imem_rd) begin
          if (aq.size() == 0) fail("rd_unexpected");
          else chk("rd_addr", 32'(imem_bus.imem_addr), 32'(aq.pop_front()));
        end
        if (instruction != NOP && instruction != prev_ins) begin
          if (prev_ins != NOP && have_cur) chk("hold_len", run_len, cur.hold);
          have_cur = wq.size() != 0;
          if (!have_cur) fail("word_unexpected");
          else begin
            cur = wq.pop_front();
            chk("word", 32'(instruction), 32'(cur.word));
          end
          run_len = 1;
        end else if (instruction != NOP) begin
          run_len++;
        end else if (prev_ins != NOP && have_cur) begin
          chk("hold_len", run_len, cur.hold);
        end
        chk("done_while_busy", 32'(done && busy), 0);
        if (!busy) begin
          chk("idle_nop", 32'(instruction), 32'(NOP));
          chk("idle_rd", 32'(imem_bus.imem_rd), 0);
        end
        if ((prev_busy && !busy) || (done && !prev_busy)) begin
          if (eq.size() == 0) fail("end_unexpected");
          else begin
            e = eq.pop_front();
            chk("end_pc", 32'(pc), 32'(e.pc));
            chk("end_done", 32'(done), 32'(e.done));
            chk("busy_len", blen, e.blen);
          end
        end
        blen = busy ? blen + 1 : 0;
        prev_busy = busy;
        prev_ins = instruction;
      end
    end
  end
  initial begin
    int len, h, sp;
    for (int k = 0; k < 256; k++) rom[k] = rand_word();
    repeat (3) begin
      @(negedge clk);
      chk("rst_nop", 32'(instruction), 32'(NOP));
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rd", 32'(imem_bus.imem_rd), 0);
    end
    @(posedge clk) #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    rom[0] = 15'b001010000001110;
    run(1, 0, 0);
    rom[1] = 15'b001110000000111;
    rom[2] = 15'b001010000101101;
    rom[3] = 15'b000100001000001;
    run(4, 0, 0);
    chk("four_pc", 32'(pc), 3);
    run(4, 2 * P + 3, 0);
    chk("halt_pc", 32'(pc), 2);
    run(4, 0, 0);
    run(0, 0, 0);
    chk("len0_busy", 32'(busy), 0);
    run(4, 0, 5);
    @(posedge clk) #1;
    start = 1'b1;
    halt = 1'b1;
    prog_len = 8'd3;
    @(posedge clk) #1;
    start = 1'b0;
    halt = 1'b0;
    chk("halt_start_idle", 32'(busy), 0);
    repeat (3) @(posedge clk);
    wq.push_back('{rom[0], HOLD});
    aq.push_back(8'd0);
    @(posedge clk) #1;
    start = 1'b1;
    prog_len = 8'd3;
    @(posedge clk) #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk) #2;
    chk("pre_rst_word", 32'(instruction), 32'(rom[0]));
    rst_n = 1'b0;
    #1;
    chk("async_rst_nop", 32'(instruction), 32'(NOP));
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_pc", 32'(pc), 0);
    wq.delete();
    aq.delete();
    eq.delete();
    model_pc = '0;
    @(posedge clk);
    @(posedge clk) #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    repeat (25) begin
      for (int k = 0; k < 16; k++) rom[k] = rand_word();
      len = $urandom_range(1, 12);
      h = $urandom_range(0, 9) < 3 ? $urandom_range(1, len * P) : 0;
      sp = (h == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len * P - 1) : 0;
      run(len, h, sp);
    end
    repeat (4) @(posedge clk);
    chk("words_left", wq.size(), 0);
    chk("reads_left", aq.size(), 0);
    chk("ends_left", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
